// File: rtl/uart_mem_loader_pkg.sv
// loader_pkg: shared constants for the UART memory loader.
//   - command bytes received from the host
//   - reply bytes sent back to the host
//   - FSM state enum
//   - bytes_for(): number of wire bytes needed to carry a field of N bits
package loader_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h4C; // 'L' single write
    localparam logic [7:0] CMD_BURST = 8'h42; // 'B' burst write
    localparam logic [7:0] CMD_DUMP  = 8'h44; // 'D' dump
    localparam logic [7:0] CMD_WORD  = 8'h57; // 'W' set test_word
    localparam logic [7:0] CMD_ADDR  = 8'h41; // 'A' set test_address
    localparam logic [7:0] CMD_RUN   = 8'h52; // 'R' cpu_run pulse
    localparam logic [7:0] CMD_HALT  = 8'h53; // 'S' cpu_halt pulse
    localparam logic [7:0] CMD_PING  = 8'h50; // 'P' ping

    localparam logic [7:0] RSP_ACK   = 8'h4B; // 'K'
    localparam logic [7:0] RSP_NAK   = 8'h4E; // 'N'

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, RX_CNT, RX_WORD, WRITE, RX_CHK,
        RD_REQ, RD_CAP, TX_BYTE, TX_WAIT, REPLY
    } state_t;

    function automatic int unsigned bytes_for(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: RAM access bus between the loader and the memory.
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_we    : one-cycle write strobe
//   mem_re    : one-cycle read strobe
//   mem_rdata : read data, valid the cycle after mem_re
// Modports: master (loader side), slave (memory side).
interface uart_mem_loader_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 18
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/uart_mem_loader_word_pack.sv
// loader_word_pack: byte <-> field conversion for the loader.
//   shift_in/byte_in : append a received byte (big-endian accumulation)
//   addr_now/word_now: field value including byte_in, so the FSM can latch a
//                      completed field in the same cycle the last byte arrives
//   load/load_word   : load a read word (zero-extended) for transmission
//   shift_out        : advance to the next byte; byte_out is the MS pending byte
module loader_word_pack import loader_pkg::*; #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_in,
    input  logic [7:0]        byte_in,
    output logic [ADDR_W-1:0] addr_now,
    output logic [DATA_W-1:0] word_now,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic              shift_out,
    output logic [7:0]        byte_out
);
    localparam int unsigned FW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned TXW = 8 * bytes_for(DATA_W);

    logic [FW-1:0]  rx_sr, rx_next;
    logic [TXW-1:0] tx_sr;

    // Truncating to the field width drops the excess MS bits of the first byte.
    assign rx_next  = FW'({rx_sr, byte_in});
    assign addr_now = rx_next[ADDR_W-1:0];
    assign word_now = rx_next[DATA_W-1:0];
    assign byte_out = tx_sr[TXW-1 -: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sr <= '0;
            tx_sr <= '0;
        end else begin
            if (shift_in) rx_sr <= rx_next;
            if (load)           tx_sr <= TXW'(load_word);
            else if (shift_out) tx_sr <= tx_sr << 8;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   clk, rst_n : clock, synchronous active-low reset
//   rx         : serial input (asynchronous, synchronised internally)
//   data       : last received byte
//   valid      : one-cycle pulse when data holds a new byte
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 443
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);
    logic        rx_s1, rx_s2;
    logic        active;
    logic [15:0] cnt;
    logic [3:0]  bit_idx;
    logic [7:0]  sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            sr      <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            valid <= 1'b0;
            if (!active) begin
                // Start edge: first sample lands half a bit later, mid start bit.
                if (!rx_s2) begin
                    active  <= 1'b1;
                    cnt     <= 16'(CLKS_PER_BIT / 2);
                    bit_idx <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 16'd1;
            end else begin
                cnt <= 16'(CLKS_PER_BIT - 1);
                if (bit_idx == 4'd0) begin
                    if (rx_s2) active <= 1'b0;   // glitch, not a real start bit
                    else       bit_idx <= 4'd1;
                end else if (bit_idx <= 4'd8) begin
                    sr      <= {rx_s2, sr[7:1]};
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    active <= 1'b0;
                    if (rx_s2) begin             // framing error drops the byte
                        data  <= sr;
                        valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter.
//   clk, rst_n : clock, synchronous active-low reset
//   send, data : load data and start a frame when not busy
//   tx         : serial output, idles high
//   busy       : high from the cycle after send until the stop bit ends
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 443
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);
    logic [9:0]  sr;
    logic [3:0]  bits_left;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx        <= 1'b1;
            busy      <= 1'b0;
            sr        <= '1;
            bits_left <= '0;
            cnt       <= '0;
        end else if (!busy) begin
            if (send) begin
                sr        <= {1'b1, data, 1'b0};
                busy      <= 1'b1;
                bits_left <= 4'd10;
                cnt       <= '0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 16'd1;
        end else if (bits_left == 4'd0) begin
            busy <= 1'b0;
        end else begin
            tx        <= sr[0];
            sr        <= {1'b1, sr[9:1]};
            bits_left <= bits_left - 4'd1;
            cnt       <= 16'(CLKS_PER_BIT - 1);
        end
    end
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: host-driven RAM loader / dumper and CPU console over UART.
//   clk, rst_n          : clock, synchronous active-low reset
//   uart_rx_i/uart_tx_o : serial link to host
//   mem                 : RAM bus (master side)
//   test_word/address   : console values set by 'W' / 'A'
//   cpu_run/cpu_halt    : one-cycle pulses from 'R' / 'S'
//   busy                : FSM not IDLE
//   err_count           : saturating error counter (bad command, bad chk, timeout)
module uart_mem_loader import loader_pkg::*; #(
    parameter int unsigned CLK_FREQ    = 51000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 18,
    parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx_i,
    output logic              uart_tx_o,
    uart_mem_loader_if.master mem,
    output logic [DATA_W-1:0] test_word,
    output logic [ADDR_W-1:0] test_address,
    output logic              cpu_run,
    output logic              cpu_halt,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [7:0]  ABW_M1 = 8'(bytes_for(ADDR_W) - 1);
    localparam logic [7:0]  BPW_M1 = 8'(bytes_for(DATA_W) - 1);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d, byte_cnt_q, byte_cnt_d, chk_q, chk_d;
    logic [7:0]        reply_q, reply_d, tx_data_q, tx_data_d, err_d;
    logic [8:0]        word_cnt_q, word_cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d, taddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, tword_d;
    logic              we_d, re_d, run_d, halt_d, tx_send_q, tx_send_d, mem_we_q, mem_re_q;
    logic              err_inc, rx_state;

    logic [7:0]        rx_data, pack_byte;
    logic              rx_valid, tx_busy, pack_shift_in, pack_load, pack_shift_out;
    logic [ADDR_W-1:0] pack_addr;
    logic [DATA_W-1:0] pack_word;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk), .rst_n(rst_n), .rx(uart_rx_i), .data(rx_data), .valid(rx_valid)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk(clk), .rst_n(rst_n), .send(tx_send_q), .data(tx_data_q),
        .tx(uart_tx_o), .busy(tx_busy)
    );

    loader_word_pack #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pack (
        .clk(clk), .rst_n(rst_n), .shift_in(pack_shift_in), .byte_in(rx_data),
        .addr_now(pack_addr), .word_now(pack_word), .load(pack_load),
        .load_word(mem.mem_rdata), .shift_out(pack_shift_out), .byte_out(pack_byte)
    );

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_re    = mem_re_q;
    assign busy          = (state_q != IDLE);
    assign rx_state      = state_q inside {RX_ADDR, RX_CNT, RX_WORD, RX_CHK};

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        byte_cnt_d     = byte_cnt_q;
        word_cnt_d     = word_cnt_q;
        chk_d          = chk_q;
        reply_d        = reply_q;
        tx_data_d      = tx_data_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        tword_d        = test_word;
        taddr_d        = test_address;
        we_d           = 1'b0;
        re_d           = 1'b0;
        run_d          = 1'b0;
        halt_d         = 1'b0;
        tx_send_d      = 1'b0;
        err_inc        = 1'b0;
        pack_shift_in  = 1'b0;
        pack_load      = 1'b0;
        pack_shift_out = 1'b0;
        tmo_d          = (rx_state && !rx_valid) ? tmo_q + 32'd1 : '0;

        case (state_q)
            IDLE: if (rx_valid) begin
                cmd_d = rx_data;
                case (rx_data)
                    CMD_LOAD, CMD_BURST, CMD_DUMP, CMD_ADDR: begin
                        byte_cnt_d = ABW_M1;
                        state_d    = RX_ADDR;
                    end
                    CMD_WORD: begin
                        byte_cnt_d = BPW_M1;
                        state_d    = RX_WORD;
                    end
                    CMD_RUN:  run_d  = 1'b1;
                    CMD_HALT: halt_d = 1'b1;
                    CMD_PING: begin
                        reply_d = RSP_ACK;
                        state_d = REPLY;
                    end
                    default:  err_inc = 1'b1;
                endcase
            end
            RX_ADDR: if (rx_valid) begin
                pack_shift_in = 1'b1;
                if (byte_cnt_q != '0) begin
                    byte_cnt_d = byte_cnt_q - 8'd1;
                end else if (cmd_q == CMD_ADDR) begin
                    taddr_d = pack_addr;
                    state_d = IDLE;
                end else begin
                    addr_d = pack_addr;
                    if (cmd_q == CMD_LOAD) begin
                        byte_cnt_d = BPW_M1;
                        state_d    = RX_WORD;
                    end else begin
                        state_d = RX_CNT;
                    end
                end
            end
            RX_CNT: if (rx_valid) begin
                word_cnt_d = (rx_data == '0) ? 9'd256 : {1'b0, rx_data};
                chk_d      = '0;
                if (cmd_q == CMD_DUMP) begin
                    re_d    = 1'b1;
                    state_d = RD_REQ;
                end else begin
                    byte_cnt_d = BPW_M1;
                    state_d    = RX_WORD;
                end
            end
            RX_WORD: if (rx_valid) begin
                pack_shift_in = 1'b1;
                chk_d         = chk_q + rx_data;
                if (byte_cnt_q != '0) begin
                    byte_cnt_d = byte_cnt_q - 8'd1;
                end else if (cmd_q == CMD_WORD) begin
                    tword_d = pack_word;
                    state_d = IDLE;
                end else begin
                    wdata_d = pack_word;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            // mem_we is high during this state.
            WRITE: begin
                if (cmd_q == CMD_LOAD) begin
                    reply_d = RSP_ACK;
                    state_d = REPLY;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    word_cnt_d = word_cnt_q - 9'd1;
                    byte_cnt_d = BPW_M1;
                    state_d    = (word_cnt_q == 9'd1) ? RX_CHK : RX_WORD;
                end
            end
            RX_CHK: if (rx_valid) begin
                reply_d = (rx_data == chk_q) ? RSP_ACK : RSP_NAK;
                err_inc = (rx_data != chk_q);
                state_d = REPLY;
            end
            // mem_re is high here; mem_rdata is valid in RD_CAP.
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                pack_load  = 1'b1;
                byte_cnt_d = BPW_M1;
                state_d    = TX_BYTE;
            end
            TX_BYTE: if (!tx_busy) begin
                tx_data_d = pack_byte;
                tx_send_d = 1'b1;
                state_d   = TX_WAIT;
            end
            REPLY: if (!tx_busy) begin
                tx_data_d = reply_q;
                tx_send_d = 1'b1;
                state_d   = TX_WAIT;
            end
            // send is visible to uart_tx here; busy is valid again next cycle.
            TX_WAIT: begin
                if (cmd_q != CMD_DUMP) begin
                    state_d = IDLE;
                end else if (byte_cnt_q != '0) begin
                    pack_shift_out = 1'b1;
                    byte_cnt_d     = byte_cnt_q - 8'd1;
                    state_d        = TX_BYTE;
                end else begin
                    addr_d     = addr_q + 1'b1;
                    word_cnt_d = word_cnt_q - 9'd1;
                    if (word_cnt_q == 9'd1) begin
                        state_d = IDLE;
                    end else begin
                        re_d    = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_state && !rx_valid && tmo_q >= TIMEOUT_CYC - 1) begin
            state_d = IDLE;
            err_inc = 1'b1;
            tmo_d   = '0;
        end

        err_d = (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            chk_q        <= '0;
            reply_q      <= '0;
            tx_data_q    <= '0;
            tx_send_q    <= 1'b0;
            tmo_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            test_word    <= '0;
            test_address <= ADDR_W'(4);
            cpu_run      <= 1'b0;
            cpu_halt     <= 1'b0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            chk_q        <= chk_d;
            reply_q      <= reply_d;
            tx_data_q    <= tx_data_d;
            tx_send_q    <= tx_send_d;
            tmo_q        <= tmo_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_we_q     <= we_d;
            mem_re_q     <= re_d;
            test_word    <= tword_d;
            test_address <= taddr_d;
            cpu_run      <= run_d;
            cpu_halt     <= halt_d;
            err_count    <= err_d;
        end
    end
endmodule
